// File: rtl/store_buffer.sv
// store_buffer: FIFO store buffer draining one store per cycle into a single-port data RAM, with ordered reads
// Ports: clk/rst (sync, active-high); wr_valid/wr_ready/wr_addr/wr_data store request;
//   rd_valid/rd_ready/rd_addr read request, rd_data/rd_data_valid result one cycle after accept;
//   flush/flush_done drain-all handshake; full/empty/count FIFO occupancy.
// Macro STORE_FWD_EN: forward pending store data to reads instead of stalling matching reads.
module store_buffer #(
  parameter int width = 32,
  parameter int addrsize = 8,
  parameter int memsize = 1 << addrsize,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [addrsize-1:0]          wr_addr,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [addrsize-1:0]          rd_addr,
  output logic [width-1:0]             rd_data,
  output logic                         rd_data_valid,
  input  logic                         flush,
  output logic                         flush_done,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [addrsize-1:0] fa_q [DEPTH];
  logic [width-1:0] fd_q [DEPTH];
  logic [width-1:0] ram [memsize];
  logic [width-1:0] rd_data_q, rd_data_d, hit_data;
  logic rd_data_valid_q, rd_data_valid_d, flush_done_q, flush_done_d;
  logic hit, push, pop, rd_acc;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign wr_ready = !full && state_q != FLUSH;
  assign push = wr_valid && wr_ready;
  assign rd_data = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign flush_done = flush_done_q;
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = rp_q;
    // Oldest to youngest, so the final match is the youngest pending store.
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp_q + PW'(k);
      if (CW'(k) < cnt_q && fa_q[idx] == rd_addr) begin
        hit = 1'b1;
        hit_data = fd_q[idx];
      end
    end
`ifdef STORE_FWD_EN
    if (push && wr_addr == rd_addr) begin
      hit = 1'b1;
      hit_data = wr_data;
    end
    rd_ready = wr_ready;
`else
    // Stall any read that would overtake a pending or same-cycle store to its address.
    rd_ready = wr_ready && !hit && !(wr_valid && wr_addr == rd_addr);
`endif
    rd_acc = rd_valid && rd_ready;
    // Full/flush already force rd_ready low, so the port drains whenever no read holds it.
    pop = !empty && !rd_acc;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    rd_data_d = rd_acc ? (hit ? hit_data : ram[rd_addr]) : rd_data_q;
    rd_data_valid_d = rd_acc;
    state_d = (state_q == IDLE) ? ((flush && !empty) ? FLUSH : IDLE) : ((cnt_d == '0) ? IDLE : FLUSH);
    flush_done_d = (state_q == IDLE) ? (flush && empty) : (cnt_d == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_data_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      flush_done_q <= flush_done_d;
    end
  end
  // Storage is not reset; reset only suppresses writes so pending stores are discarded.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fa_q[wp_q] <= wr_addr;
      fd_q[wp_q] <= wr_data;
    end
    if (!rst && pop) ram[fa_q[rp_q]] <= fd_q[rp_q];
  end
endmodule
